proj_to_screen: RTL and testbench



---
 rtl/proj_to_screen.sv | 127 ++++++++++++
 tb/tb_proj_to_screen.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/proj_to_screen.sv
// Float32 projected (x,y) -> integer screen pixel; 2^SCALE_LOG2 viewport scale, shared converter, 4-cycle FSM.
// Holds result under ready_in backpressure; PROJ_SCREEN_CLAMP_EN clamps to the screen instead of wrapping.
module proj_to_screen #(
   parameter int SCREEN_W   = 1280,
   parameter int SCREEN_H   = 720,
   parameter int SCALE_LOG2 = 8,
   parameter int X_W        = 11,
   parameter int Y_W        = 10
) (
   input  logic                clk_in,
   input  logic                rst_n_in,
   input  logic [1:0][31:0]    coor_in,
   input  logic                valid_in,
   output logic                ready_out,
   output logic [X_W-1:0]      x_out,
   output logic [Y_W-1:0]      y_out,
   output logic                offscreen_out,
   output logic                valid_out,
   input  logic                ready_in
);

   typedef enum logic [1:0] {IDLE, CONV_X, CONV_Y, DONE} state_t;

   localparam logic signed [32:0] CX   = 33'(SCREEN_W / 2);
   localparam logic signed [32:0] CY   = 33'(SCREEN_H / 2);
   localparam logic signed [32:0] XMAX = 33'(SCREEN_W - 1);
   localparam logic signed [32:0] YMAX = 33'(SCREEN_H - 1);

   state_t            state, next_state;
   logic [31:0]       xf, yf, ix, conv;
   logic signed [32:0] px, py;
   logic [X_W-1:0]    xs;
   logic [Y_W-1:0]    ys;
   logic              off;

   // Truncating float->int with the viewport scale folded into the exponent; NaN saturates positive.
   function automatic logic [31:0] f2i(input logic [31:0] f);
      logic              s, sat_s;
      logic [7:0]        e;
      logic signed [9:0] eff;
      logic [31:0]       m24, mag;
      s     = f[31];
      e     = f[30:23];
      m24   = {8'd0, 1'b1, f[22:0]};
      eff   = $signed({2'b00, e}) - 10'sd127 + 10'(SCALE_LOG2);
      sat_s = s & ~((e == 8'hFF) && (f[22:0] != 23'd0));
      mag   = (eff <= 10'sd23) ? (m24 >> (5'd23 - eff[4:0])) : (m24 << (eff[4:0] - 5'd23));
      if (e == 8'd0)
         f2i = 32'd0;
      else if ((e == 8'hFF) || (eff > 10'sd30))
         f2i = sat_s ? 32'hC000_0000 : 32'h4000_0000;
      else if (eff < 10'sd0)
         f2i = 32'd0;
      else
         f2i = s ? -mag : mag;
   endfunction

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in)
         state <= IDLE;
      else
         state <= next_state;
   end

   always_comb begin
      next_state = state;
      ready_out  = 1'b0;
      valid_out  = 1'b0;
      case (state)
         IDLE: begin
            ready_out = 1'b1;
            if (valid_in)
               next_state = CONV_X;
         end
         CONV_X: next_state = CONV_Y;
         CONV_Y: next_state = DONE;
         DONE: begin
            valid_out = 1'b1;
            if (ready_in)
               next_state = IDLE;
         end
         default: next_state = IDLE;
      endcase
   end

   assign conv = f2i((state == CONV_X) ? xf : yf);

   // In CONV_Y the converter output is iy; x uses the value registered one cycle earlier.
   always_comb begin
      px  = CX + $signed({ix[31], ix});
      py  = CY - $signed({conv[31], conv});
      off = (px < 33'sd0) || (px > XMAX) || (py < 33'sd0) || (py > YMAX);
`ifdef PROJ_SCREEN_CLAMP_EN
      xs = (px < 33'sd0) ? '0 : ((px > XMAX) ? X_W'(SCREEN_W - 1) : px[X_W-1:0]);
      ys = (py < 33'sd0) ? '0 : ((py > YMAX) ? Y_W'(SCREEN_H - 1) : py[Y_W-1:0]);
`else
      xs = px[X_W-1:0];
      ys = py[Y_W-1:0];
`endif
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         xf            <= '0;
         yf            <= '0;
         ix            <= '0;
         x_out         <= '0;
         y_out         <= '0;
         offscreen_out <= 1'b0;
      end else begin
         case (state)
            IDLE: if (valid_in) begin
               xf <= coor_in[1];
               yf <= coor_in[0];
            end
            CONV_X: ix <= conv;
            CONV_Y: begin
               x_out         <= xs;
               y_out         <= ys;
               offscreen_out <= off;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_proj_to_screen.sv
// Directed bench for proj_to_screen: reset, conversion vectors, boundaries, backpressure, back-to-back.
module tb_proj_to_screen;

   logic             clk_in = 1'b0;
   logic             rst_n_in;
   logic [1:0][31:0] coor_in;
   logic             valid_in, ready_out, valid_out, ready_in, offscreen_out;
   logic [10:0]      x_out;
   logic [9:0]       y_out;

   int total = 0;
   int bad   = 0;

   logic      collect = 1'b0;
   int        qx[$];
   int        qy[$];

   always #5 clk_in = ~clk_in;

   proj_to_screen dut (
      .clk_in        (clk_in),
      .rst_n_in      (rst_n_in),
      .coor_in       (coor_in),
      .valid_in      (valid_in),
      .ready_out     (ready_out),
      .x_out         (x_out),
      .y_out         (y_out),
      .offscreen_out (offscreen_out),
      .valid_out     (valid_out),
      .ready_in      (ready_in)
   );

   always @(negedge clk_in)
      if (collect && valid_out && ready_in) begin
         qx.push_back(int'(x_out));
         qy.push_back(int'(y_out));
      end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   task automatic wait_ready(input string tag);
      int n = 0;
      while (!ready_out && n < 50) begin
         @(negedge clk_in);
         n++;
      end
      check({tag, "_rdy"}, 64'(ready_out), 64'd1);
   endtask

   task automatic run_vec(input string tag, input logic [31:0] xb, input logic [31:0] yb,
                          input int ex, input int ey, input logic eo);
      int lat;
      @(negedge clk_in);
      coor_in[1] = xb;
      coor_in[0] = yb;
      valid_in   = 1'b1;
      wait_ready(tag);
      @(posedge clk_in);
      @(negedge clk_in);
      valid_in = 1'b0;
      lat = 1;
      while (!valid_out && lat < 20) begin
         @(negedge clk_in);
         lat++;
      end
      check({tag, "_lat"}, 64'(lat), 64'd3);
      check({tag, "_x"}, 64'(x_out), 64'(ex));
      check({tag, "_y"}, 64'(y_out), 64'(ey));
      check({tag, "_off"}, 64'(offscreen_out), 64'(eo));
      @(negedge clk_in);
      check({tag, "_vdrop"}, 64'(valid_out), 64'd0);
      check({tag, "_rrise"}, 64'(ready_out), 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic seen, stable;
      int   n;
      logic [31:0] bx[3];
      logic [31:0] by[3];
      int   ebx[3];
      int   eby[3];
      time  tacc[3];

      rst_n_in = 1'b0;
      valid_in = 1'b0;
      ready_in = 1'b1;
      coor_in  = '0;
      repeat (3) @(negedge clk_in);
      check("rst_ready", 64'(ready_out), 64'd1);
      check("rst_valid", 64'(valid_out), 64'd0);
      check("rst_x", 64'(x_out), 64'd0);
      check("rst_y", 64'(y_out), 64'd0);
      check("rst_off", 64'(offscreen_out), 64'd0);
      rst_n_in = 1'b1;

      // 1.0 -> ix=256, -1.0 -> iy=-256
      run_vec("one", 32'h3F80_0000, 32'hBF80_0000, 896, 616, 1'b0);

      // Reset while converting: async clear, and the aborted vertex never appears.
      @(negedge clk_in);
      coor_in[1] = 32'h4020_0000;
      coor_in[0] = 32'h7FC0_0000;
      valid_in   = 1'b1;
      @(posedge clk_in);
      @(negedge clk_in);
      valid_in = 1'b0;
      @(posedge clk_in);
      #2 rst_n_in = 1'b0;
      #1;
      check("midrst_valid", 64'(valid_out), 64'd0);
      check("midrst_ready", 64'(ready_out), 64'd1);
      check("midrst_x", 64'(x_out), 64'd0);
      check("midrst_y", 64'(y_out), 64'd0);
      @(negedge clk_in);
      rst_n_in = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk_in);
         seen |= valid_out;
      end
      check("midrst_noout", 64'(seen), 64'd0);

      run_vec("zero", 32'h0000_0000, 32'h8000_0000, 640, 360, 1'b0);
`ifdef PROJ_SCREEN_CLAMP_EN
      run_vec("nan", 32'h4020_0000, 32'h7FC0_0000, 1279, 0, 1'b1);
      run_vec("sat", 32'h4F00_0000, 32'hFF80_0000, 1279, 719, 1'b1);
`else
      // px=1280 wraps to 1280 in 11 bits; 360-2^30 and 360+2^30 are 360 mod 1024.
      run_vec("nan", 32'h4020_0000, 32'h7FC0_0000, 1280, 360, 1'b1);
      run_vec("sat", 32'h4F00_0000, 32'hFF80_0000, 640, 360, 1'b1);
`endif
      // 0.5 -> 128; 2^-8 -> 1 (eff=0); 2^-9 -> 0 (eff<0)
      run_vec("half", 32'h3F00_0000, 32'h3B80_0000, 768, 359, 1'b0);
      run_vec("tiny", 32'h3F00_0000, 32'h3B00_0000, 768, 360, 1'b0);
      // -2.5 -> -640 gives px=0; -359/256 gives py=719: both edges on-screen
      run_vec("edge", 32'hC020_0000, 32'hBFB3_8000, 0, 719, 1'b0);

      // Backpressure
      ready_in = 1'b0;
      @(negedge clk_in);
      coor_in[1] = 32'h3F80_0000;
      coor_in[0] = 32'hBF80_0000;
      valid_in   = 1'b1;
      wait_ready("bp");
      @(posedge clk_in);
      @(negedge clk_in);
      valid_in = 1'b0;
      n = 0;
      while (!valid_out && n < 20) begin
         @(negedge clk_in);
         n++;
      end
      check("bp_valid", 64'(valid_out), 64'd1);
      coor_in[1] = 32'h4020_0000;
      coor_in[0] = 32'h7FC0_0000;
      valid_in   = 1'b1;
      stable = 1'b1;
      repeat (5) begin
         @(negedge clk_in);
         stable &= valid_out && (x_out == 11'd896) && (y_out == 10'd616) && !ready_out;
      end
      check("bp_stable", 64'(stable), 64'd1);
      valid_in = 1'b0;
      ready_in = 1'b1;
      @(negedge clk_in);
      check("bp_vdrop", 64'(valid_out), 64'd0);
      check("bp_rrise", 64'(ready_out), 64'd1);
      seen = 1'b0;
      repeat (6) begin
         @(negedge clk_in);
         seen |= valid_out;
      end
      check("bp_ignored", 64'(seen), 64'd0);

      // Back-to-back with valid_in held
      bx[0] = 32'h3F80_0000; by[0] = 32'hBF80_0000; ebx[0] = 896; eby[0] = 616;
      bx[1] = 32'h0000_0000; by[1] = 32'h8000_0000; ebx[1] = 640; eby[1] = 360;
      bx[2] = 32'hC020_0000; by[2] = 32'hBFB3_8000; ebx[2] = 0;   eby[2] = 719;
      collect = 1'b1;
      @(negedge clk_in);
      coor_in[1] = bx[0];
      coor_in[0] = by[0];
      valid_in   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         wait_ready("b2b");
         @(posedge clk_in);
         tacc[i] = $time;
         @(negedge clk_in);
         if (i < 2) begin
            coor_in[1] = bx[i+1];
            coor_in[0] = by[i+1];
         end else begin
            valid_in = 1'b0;
         end
      end
      repeat (8) @(negedge clk_in);
      collect = 1'b0;
      check("b2b_gap1", 64'(tacc[1] - tacc[0]), 64'd40);
      check("b2b_gap2", 64'(tacc[2] - tacc[1]), 64'd40);
      check("b2b_count", 64'(qx.size()), 64'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < qx.size()) begin
            check("b2b_x", 64'(qx[i]), 64'(ebx[i]));
            check("b2b_y", 64'(qy[i]), 64'(eby[i]));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
